ucsbece154a_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the multicycle RISC-V processor's data bus, alongside `ucsbece154a_mem`. It decodes processor stores and loads in its own address window and buffers outgoing bytes in a small FIFO. It serialises each byte as an 8N1 frame on a single `tx` line at a programmable bit period. Programs print by storing bytes to TXDATA and polling STATUS.

---
 rtl/ucsbece154a_uart_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_ucsbece154a_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_uart_tx.sv
// ucsbece154a_uart_tx
// Memory-mapped 8N1 UART transmitter for the multicycle RISC-V data bus.
// Stores to TXDATA queue bytes in a small circular FIFO; a four-state FSM
// pops bytes and shifts them out LSB first on `tx`, each bit lasting
// DIVISOR+1 clock cycles.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-low reset
//   a      in   32  processor byte address (bits [1:0] ignored)
//   wd     in   32  processor write data
//   we     in   1   processor write enable (qualified by address decode)
//   rd     out  32  combinational read data, zero outside the window
//   tx     out  1   registered serial output, idle high
//
// Register map (word offsets from BASE_ADDR):
//   +0 TXDATA  write pushes wd[7:0], reads 0
//   +4 STATUS  {COUNT[8:4], OVF, BUSY, EMPTY, FULL}; any write clears OVF
//   +8 DIVISOR R/W, 16 bits, zero-extended on read
//   +12        no effect, reads 0
module ucsbece154a_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Address decode: a four-word block starting at BASE_ADDR.
  logic [29:0] word_off_s;
  logic        in_win_s;
  logic [1:0]  reg_sel_s;
  logic        wr_txdata_s;
  logic        wr_status_s;
  logic        wr_div_s;

  assign word_off_s  = a[31:2] - BASE_ADDR[31:2];
  assign in_win_s    = (word_off_s < 30'd4);
  assign reg_sel_s   = word_off_s[1:0];
  assign wr_txdata_s = we && in_win_s && (reg_sel_s == 2'd0);
  assign wr_status_s = we && in_win_s && (reg_sel_s == 2'd1);
  assign wr_div_s    = we && in_win_s && (reg_sel_s == 2'd2);

  // Bits that carry no meaning for this peripheral.
  logic unused_bits_s;
  assign unused_bits_s = ^{wd[31:16], a[1:0]};

  // FIFO state
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [4:0]       count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_s;

  assign full_s    = (count_r == 5'(FIFO_DEPTH));
  assign empty_s   = (count_r == 5'd0);
  // A full FIFO drops the byte even if a pop happens on the same edge.
  assign push_ok_s = wr_txdata_s && !full_s;

  // Control/status registers
  logic        ovf_r;
  logic [15:0] div_r;

  // TX datapath and FSM
  state_t      state_r;
  state_t      state_n;
  logic [15:0] cnt_r;
  logic [15:0] cnt_n;
  logic [7:0]  shift_r;
  logic [7:0]  shift_n;
  logic [2:0]  idx_r;
  logic [2:0]  idx_n;
  logic        tx_r;
  logic        tx_n;
  logic        busy_s;

  assign busy_s = (state_r != IDLE);

  // FIFO storage write port; pointers are reset separately so stale data is harmless.
  always_ff @(posedge clk) begin
    if (push_ok_s && reset) begin
      fifo_mem_r[wr_ptr_r] <= wd[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= 5'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag and the bit-period divisor register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_r <= 1'b0;
      div_r <= DIV_RESET;
    end else begin
      if (wr_txdata_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s) begin
        ovf_r <= 1'b0;
      end
      if (wr_div_s) begin
        div_r <= wd[15:0];
      end
    end
  end

  // FSM state, bit timer, shifter and the registered serial line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      shift_r <= 8'd0;
      idx_r   <= 3'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      shift_r <= shift_n;
      idx_r   <= idx_n;
      tx_r    <= tx_n;
    end
  end

  // Next-state logic; every bit boundary reloads the timer from the current DIVISOR.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    shift_n = shift_r;
    idx_n   = idx_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_n = START;
          pop_s   = 1'b1;
          shift_n = fifo_mem_r[rd_ptr_r];
          cnt_n   = div_r;
          idx_n   = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (cnt_r == 16'd0) begin
          state_n = DATA;
          cnt_n   = div_r;
        end else begin
          cnt_n = cnt_r - 16'd1;
        end
      end
      DATA: begin
        if (cnt_r == 16'd0) begin
          cnt_n   = div_r;
          shift_n = {1'b0, shift_r[7:1]};
          idx_n   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_n = STOP;
          end else begin
            state_n = DATA;
          end
        end else begin
          cnt_n = cnt_r - 16'd1;
        end
      end
      STOP: begin
        if (cnt_r == 16'd0) begin
          if (!empty_s) begin
            // Back-to-back frame: no idle cycle between stop and start.
            state_n = START;
            pop_s   = 1'b1;
            shift_n = fifo_mem_r[rd_ptr_r];
            cnt_n   = div_r;
            idx_n   = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, so tx is a pure register output.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign tx = tx_r;

  // Read mux: combinational from address and internal state.
  always_comb begin
    rd = 32'd0;
    if (in_win_s) begin
      case (reg_sel_s)
        2'd1:    rd = {23'd0, count_r, ovf_r, busy_s, empty_s, full_s};
        2'd2:    rd = {16'd0, div_r};
        default: rd = 32'd0;
      endcase
    end else begin
      rd = 32'd0;
    end
  end

endmodule

// File: tb/tb_ucsbece154a_uart_tx.sv
// Testbench for ucsbece154a_uart_tx: directed and randomized bus traffic,
// with the serial line checked against frames computed from the bytes sent.
module tb_ucsbece154a_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0100;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'd4;
  localparam logic [31:0] DIVR = BASE + 32'd8;
  localparam int LOG_N = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  logic tx_log [0:LOG_N-1];

  ucsbece154a_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .rd    (rd),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc = cyc + 1;

  // tx_log[n] holds the line level following posedge n.
  always @(negedge clk) if (cyc < LOG_N) tx_log[cyc] = tx;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input int count, input bit ovf, input bit busy);
    int w;
    w = count * 16 + (ovf ? 8 : 0) + (busy ? 4 : 0) + ((count == 0) ? 2 : 0) + ((count == 4) ? 1 : 0);
    return 32'(w);
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    last_edge = cyc;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic wait_log(input int idx);
    for (int k = 0; k < 20000 && cyc <= idx; k++) @(posedge clk);
    #1;
    if (cyc <= idx) begin
      checks++;
      errors++;
      $error("FAIL wait_timeout observed=%0d expected=%0d", cyc, idx + 1);
    end
  endtask

  // One 8N1 frame; frame bits with index < sw last d0+1 cycles, the rest d1+1.
  task automatic check_frame(input int start, input logic [7:0] b, input int d0,
                             input int d1, input int sw, output int nxt);
    int idx;
    logic expb;
    int dur;
    idx = start;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) expb = 1'b0;
      else if (j == 9) expb = 1'b1;
      else expb = b[j-1];
      dur = (j < sw) ? d0 + 1 : d1 + 1;
      for (int k = 0; k < dur; k++) begin
        wait_log(idx);
        check($sformatf("frame_%02h_bit%0d_cyc%0d", b, j, k), {31'd0, tx_log[idx]}, {31'd0, expb});
        idx++;
      end
    end
    nxt = idx;
  endtask

  task automatic check_idle(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      wait_log(start + i);
      check($sformatf("idle_at_%0d", start + i), {31'd0, tx_log[start + i]}, 32'd1);
    end
  endtask

  initial begin
    int e;
    int nx;
    int d;
    int n;
    int r;
    logic [7:0] b;
    logic [7:0] q[$];

    reset = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    bus_read(STA, 32'h2, "reset_status");
    bus_read(DIVR, 32'h3, "reset_div");
    check("reset_tx", {31'd0, tx}, 32'd1);

    // Single frame 0xA5 at DIVISOR=3
    bus_write(DIVR, 32'd3);
    bus_write(TXD, 32'h0000_00A5);
    e = last_edge;
    bus_read(STA, status_word(1, 1'b0, 1'b0), "after_push_status");
    @(posedge clk); #1;
    bus_read(STA, status_word(0, 1'b0, 1'b1), "after_pop_status");
    check_idle(e, 1);
    check_frame(e + 1, 8'hA5, 3, 3, 10, nx);
    check_idle(nx, 5);
    bus_read(STA, 32'h2, "a5_done_status");

    // Five back-to-back bytes at DIVISOR=0, then an overflowing sixth
    bus_write(DIVR, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      bus_write(TXD, 32'(i));
      if (i == 1) e = last_edge;
    end
    bus_read(STA, status_word(4, 1'b0, 1'b1), "full_status");
    bus_write(TXD, 32'h06);
    bus_read(STA, status_word(4, 1'b1, 1'b1), "ovf_status");
    bus_write(STA, 32'hFFFF_FFFF);
    bus_read(STA, status_word(4, 1'b0, 1'b1), "ovf_clear_status");
    nx = e + 1;
    for (int i = 1; i <= 5; i++) check_frame(nx, 8'(i), 0, 0, 10, nx);
    check_idle(nx, 5);
    bus_read(STA, 32'h2, "burst_done_status");

    // Randomized bursts with random divisors
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 5);
      q.delete();
      bus_write(DIVR, 32'(d));
      bus_read(DIVR, 32'(d), "rand_div_readback");
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        bus_write(TXD, {24'd0, b});
        if (i == 0) e = last_edge;
      end
      nx = e + 1;
      for (int i = 0; i < n; i++) check_frame(nx, q[i], d, d, 10, nx);
      check_idle(nx, 3);
      bus_read(STA, 32'h2, "rand_done_status");
    end

    // DIVISOR 1 -> 7 written during data bit 2
    bus_write(DIVR, 32'd1);
    b = 8'($urandom);
    bus_write(TXD, {24'd0, b});
    e = last_edge;
    repeat (7) @(posedge clk);
    #1;
    bus_write(DIVR, 32'd7);
    bus_read(DIVR, 32'd7, "div_change_readback");
    check_frame(e + 1, b, 1, 7, 4, nx);
    check_idle(nx, 3);

    // Reset mid-frame with three bytes queued
    bus_write(DIVR, 32'd3);
    for (int i = 0; i < 4; i++) begin
      bus_write(TXD, 32'($urandom_range(0, 255)));
      if (i == 0) e = last_edge;
    end
    bus_read(STA, status_word(3, 1'b0, 1'b1), "queued_status");
    repeat (8) @(posedge clk);
    #1;
    check_idle(e, 1);
    wait_log(e + 1);
    check("midframe_start_bit", {31'd0, tx_log[e + 1]}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    r = cyc;
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    bus_read(STA, 32'h2, "midreset_status");
    bus_read(DIVR, 32'h3, "midreset_div");
    check_idle(r, 60);
    bus_read(STA, 32'h2, "post_reset_status");
    bus_read(32'h1000_0000, 32'd0, "outside_window");
    bus_read(BASE + 32'd12, 32'd0, "offset12_read");
    bus_read(TXD, 32'd0, "txdata_read");
    bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
    bus_read(STA, 32'h2, "offset12_write_status");
    bus_read(DIVR, 32'h3, "offset12_write_div");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
